// File: rtl/line_fill_buffer.sv
// Line fill buffer: fetches one cache line as a critical-word-first wrapping burst,
// assembles it into LineData and flags the critical word and line completion.
module line_fill_buffer #(
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      LB_Enable,
    input  logic [31:0]               WordAddress,
    output logic [31:0]               LineAddress,
    output logic                      LB_FirstWord,
    output logic                      LB_Completed,
    output logic                      LB_Error,
    output logic [31:0]               CritWordData,
    output logic [32*LINE_WORDS-1:0]  LineData,
    output logic                      M_ARValid,
    input  logic                      M_ARReady,
    output logic [31:0]               M_ARAddr,
    input  logic                      M_RValid,
    output logic                      M_RReady,
    input  logic [31:0]               M_RData,
    input  logic                      M_RLast
);
    localparam int unsigned PTR_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(LINE_WORDS + 1);
    localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic             abort;
    logic             run;
    logic             beat;
    logic             last_beat;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] start_ptr;

    assign beat      = M_RValid && M_RReady;
    assign last_beat = (cnt == LAST_BEAT);
    assign next_ptr  = (ptr == PTR_MAX) ? '0 : ptr + PTR_W'(1);
    assign start_ptr = (LINE_WORDS > 1) ? WordAddress[PTR_W+1:2] : '0;

    // Reset release is retimed so no fill starts on the first edge after release.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) run <= 1'b0;
        else      run <= 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            abort        <= 1'b0;
            LineAddress  <= '0;
            LB_FirstWord <= 1'b0;
            LB_Completed <= 1'b0;
            LB_Error     <= 1'b0;
            CritWordData <= '0;
            LineData     <= '0;
            M_ARValid    <= 1'b0;
            M_ARAddr     <= '0;
            M_RReady     <= 1'b0;
        end else begin
            LB_FirstWord <= 1'b0;
            // Every accepted beat advances the wrap pointer and checks RLast placement.
            if (beat) begin
                ptr <= next_ptr;
                cnt <= cnt + CNT_W'(1);
                if (M_RLast != last_beat) LB_Error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (LB_Enable && run) begin
                        LineAddress <= {WordAddress[31:5], 5'b0};
                        M_ARAddr    <= {WordAddress[31:2], 2'b00};
                        M_ARValid   <= 1'b1;
                        ptr         <= start_ptr;
                        cnt         <= '0;
                        abort       <= 1'b0;
                        LB_Error    <= 1'b0;
                        state       <= ADDR;
                    end
                end
                ADDR: begin
                    if (!LB_Enable) abort <= 1'b1;
                    if (M_ARReady) begin
                        M_ARValid <= 1'b0;
                        M_RReady  <= 1'b1;
                        state     <= (abort || !LB_Enable) ? DRAIN : DATA;
                    end
                end
                DATA: begin
                    if (!LB_Enable) begin
                        state <= DRAIN;
                        if (beat && last_beat) begin
                            state    <= IDLE;
                            M_RReady <= 1'b0;
                        end
                    end else if (beat) begin
                        LineData[32*ptr +: 32] <= M_RData;
                        if (cnt == '0) begin
                            CritWordData <= M_RData;
                            LB_FirstWord <= 1'b1;
                        end
                        if (last_beat) begin
                            state        <= DONE;
                            LB_Completed <= 1'b1;
                            M_RReady     <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (!LB_Enable) begin
                        LB_Completed <= 1'b0;
                        state        <= IDLE;
                    end
                end
                DRAIN: begin
                    if (beat && last_beat) begin
                        state    <= IDLE;
                        M_RReady <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_fill_buffer.sv
// Bench for line_fill_buffer: a memory slave with random gaps and delays feeds fills,
// and a transaction-level model predicts every output on every cycle.
`timescale 1ns/1ps
module tb_line_fill_buffer;
    localparam int LW = 8;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              LB_Enable;
    logic [31:0]       WordAddress;
    logic [31:0]       LineAddress;
    logic              LB_FirstWord;
    logic              LB_Completed;
    logic              LB_Error;
    logic [31:0]       CritWordData;
    logic [32*LW-1:0]  LineData;
    logic              M_ARValid;
    logic              M_ARReady;
    logic [31:0]       M_ARAddr;
    logic              M_RValid;
    logic              M_RReady;
    logic [31:0]       M_RData;
    logic              M_RLast;

    line_fill_buffer #(.LINE_WORDS(LW)) dut (
        .Clk(Clk), .Rst(Rst), .LB_Enable(LB_Enable), .WordAddress(WordAddress),
        .LineAddress(LineAddress), .LB_FirstWord(LB_FirstWord), .LB_Completed(LB_Completed),
        .LB_Error(LB_Error), .CritWordData(CritWordData), .LineData(LineData),
        .M_ARValid(M_ARValid), .M_ARReady(M_ARReady), .M_ARAddr(M_ARAddr),
        .M_RValid(M_RValid), .M_RReady(M_RReady), .M_RData(M_RData), .M_RLast(M_RLast)
    );

    always #5 Clk = ~Clk;

    // Model: a fill is an outstanding address request, then a number of beats still owed.
    bit          m_arp, m_done, m_abort, m_err, m_first;
    int          m_left, m_cnt, m_base;
    logic [31:0] m_araddr, m_laddr, m_crit;
    logic [31:0] m_line [LW];
    logic [31:0] burst [LW];

    bit          en, dropped, fixed, tog;
    int          ar_delay, ar_wait, rv_pct, drop_after, err_beat, first_seen;
    int          n_pass, n_total;
    logic [31:0] wa, last_araddr;

    task automatic check(input string name, input logic [32*LW-1:0] act, input logic [32*LW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [32*LW-1:0] exp_vec();
        logic [32*LW-1:0] v;
        for (int i = 0; i < LW; i++) v[32*i +: 32] = m_line[i];
        return v;
    endfunction

    task automatic model_reset();
        m_arp = 0; m_done = 0; m_abort = 0; m_err = 0; m_first = 0;
        m_left = 0; m_cnt = 0; m_base = 0;
        m_araddr = '0; m_laddr = '0; m_crit = '0;
        for (int i = 0; i < LW; i++) m_line[i] = '0;
    endtask

    task automatic compare_all();
        check("ARValid", M_ARValid, m_arp);
        if (m_arp) check("ARAddr", M_ARAddr, m_araddr);
        check("RReady", M_RReady, m_left > 0);
        check("FirstWord", LB_FirstWord, m_first);
        check("Completed", LB_Completed, m_done);
        check("Error", LB_Error, m_err);
        check("LineAddress", LineAddress, m_laddr);
        check("CritWordData", CritWordData, m_crit);
        check("LineData", LineData, exp_vec());
        if (LB_FirstWord) first_seen++;
        if (M_ARValid) last_araddr = M_ARAddr;
    endtask

    // One clock: drive inputs, advance the model across the edge, compare after it.
    task automatic cycle();
        int idx;
        if (drop_after >= 0 && (m_arp || m_left > 0) && m_cnt >= drop_after) dropped = 1;
        LB_Enable   = en && !dropped;
        WordAddress = wa;
        M_ARReady   = m_arp ? (ar_wait >= ar_delay) : ($urandom_range(0, 1) == 1);
        tog = !tog;
        if (m_left > 0 && ((rv_pct < 0) ? tog : ($urandom_range(0, 99) < rv_pct))) begin
            M_RValid = 1'b1;
            M_RData  = burst[m_cnt];
            M_RLast  = (m_cnt == LW - 1) ^ (m_cnt == err_beat);
        end else begin
            M_RValid = (m_left == 0) && ($urandom_range(0, 3) == 0);
            M_RData  = $urandom;
            M_RLast  = $urandom_range(0, 1) == 1;
        end
        #1;
        m_first = 0;
        if (!m_arp && m_left == 0 && !m_done) begin
            if (LB_Enable) begin
                m_arp = 1; m_araddr = {wa[31:2], 2'b00}; m_laddr = {wa[31:5], 5'b0};
                m_base = int'(wa[4:2]); m_cnt = 0; m_err = 0; m_abort = 0; ar_wait = 0;
            end
        end else if (m_arp) begin
            if (!LB_Enable) m_abort = 1;
            ar_wait++;
            if (M_ARReady) begin
                m_arp = 0; m_left = LW;
                for (int i = 0; i < LW; i++) burst[i] = fixed ? (32'hD000_0000 + 32'(i)) : $urandom;
            end
        end else if (m_left > 0) begin
            if (!LB_Enable) m_abort = 1;
            if (M_RValid) begin
                idx = (m_base + m_cnt) % LW;
                if (!m_abort) begin
                    m_line[idx] = M_RData;
                    if (m_cnt == 0) begin m_crit = M_RData; m_first = 1; end
                end
                if (M_RLast != (m_cnt == LW - 1)) m_err = 1;
                m_cnt++; m_left--;
                if (m_left == 0 && !m_abort) m_done = 1;
            end
        end else if (!LB_Enable) m_done = 0;
        @(posedge Clk); #1;
        compare_all();
        @(negedge Clk);
    endtask

    task automatic fill(input logic [31:0] a, input int ard, input int rvp,
                        input int drop, input int eb, input bit fx);
        int guard;
        guard = 0;
        wa = a; ar_delay = ard; rv_pct = rvp; drop_after = drop; err_beat = eb; fixed = fx;
        dropped = 0; first_seen = 0; en = 1;
        cycle();
        wa = $urandom;
        while ((m_arp || m_left > 0) && guard < 300) begin cycle(); guard++; end
        if (guard >= 300) begin
            n_total++;
            $display("FAIL fill_timeout: got %0d cycles required fewer than 300", guard);
        end
        check("FirstWordPulses", 32'(first_seen), (drop == 0) ? 1'b0 : 1'b1);
        if (!dropped) begin cycle(); cycle(); end
    endtask

    task automatic release_fill();
        en = 0; cycle(); cycle();
    endtask

    initial begin
        logic [32*LW-1:0] ld;
        n_pass = 0; n_total = 0; tog = 0;
        en = 0; dropped = 0; wa = '0; drop_after = -1; err_beat = -1; ar_delay = 0; rv_pct = 100;
        Rst = 1'b0; LB_Enable = 0; WordAddress = '0; M_ARReady = 0; M_RValid = 0; M_RData = '0; M_RLast = 0;
        model_reset();
        repeat (3) @(negedge Clk);
        compare_all();
        check("rst_ARAddr", M_ARAddr, 32'h0);
        Rst = 1'b1;
        repeat (3) cycle();

        // Critical word 5, immediate ARReady, back-to-back beats
        fill(32'h0000_1234, 0, 100, -1, -1, 1);
        ld = LineData;
        check("lit_ARAddr", last_araddr, 32'h0000_1234);
        check("lit_LineAddress", LineAddress, 32'h0000_1220);
        check("lit_slot5", ld[32*5 +: 32], 32'hD000_0000);
        check("lit_slot7", ld[32*7 +: 32], 32'hD000_0002);
        check("lit_slot0", ld[32*0 +: 32], 32'hD000_0003);
        check("lit_slot4", ld[32*4 +: 32], 32'hD000_0007);
        check("lit_crit", CritWordData, 32'hD000_0000);
        check("lit_completed", LB_Completed, 1'b1);
        release_fill();

        // Delayed ARReady with alternating RValid gaps
        fill(32'h0000_2468, 3, -1, -1, -1, 0);
        release_fill();

        // Enable dropped after four beats, then a normal fill
        fill(32'h0000_3000, 1, 100, 4, -1, 0);
        check("lit_drop_nocompl", LB_Completed, 1'b0);
        release_fill();
        fill(32'h0000_3008, 0, 100, -1, -1, 0);
        release_fill();

        // Enable dropped while the address is still outstanding
        fill(32'h0000_3100, 2, 100, 0, -1, 0);
        release_fill();

        // RLast on beat 5: sticky error, cleared by the next fill
        fill(32'h0000_4010, 0, 100, -1, 5, 0);
        check("lit_error", LB_Error, 1'b1);
        release_fill();
        check("lit_error_sticky", LB_Error, 1'b1);
        fill(32'h0000_4020, 0, 100, -1, -1, 0);
        check("lit_error_cleared", LB_Error, 1'b0);
        release_fill();

        // Critical word 7 wraps to slot 0
        fill(32'h0000_501C, 0, 100, -1, -1, 1);
        ld = LineData;
        check("lit_wrap_slot7", ld[32*7 +: 32], 32'hD000_0000);
        check("lit_wrap_slot0", ld[32*0 +: 32], 32'hD000_0001);
        check("lit_wrap_slot6", ld[32*6 +: 32], 32'hD000_0007);
        release_fill();

        // Reset in the middle of a burst
        wa = 32'h0000_6004; ar_delay = 0; rv_pct = 100; drop_after = -1; err_beat = -1;
        fixed = 0; dropped = 0; en = 1;
        for (int g = 0; g < 50 && m_cnt < 3; g++) cycle();
        #2 Rst = 1'b0;
        #1;
        check("rstmid_ARValid", M_ARValid, 1'b0);
        check("rstmid_RReady", M_RReady, 1'b0);
        check("rstmid_First", LB_FirstWord, 1'b0);
        check("rstmid_Compl", LB_Completed, 1'b0);
        check("rstmid_Error", LB_Error, 1'b0);
        check("rstmid_LineAddr", LineAddress, 32'h0);
        check("rstmid_Crit", CritWordData, 32'h0);
        check("rstmid_LineData", LineData, '0);
        check("rstmid_ARAddr", M_ARAddr, 32'h0);
        model_reset();
        en = 0; LB_Enable = 0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        repeat (3) cycle();
        fill(32'h0000_600C, 1, 80, -1, -1, 0);
        release_fill();

        // Randomised fills
        for (int n = 0; n < 25; n++) begin
            int drp, eb, rvp;
            drp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
            eb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
            case ($urandom_range(0, 2))
                0: rvp = 100;
                1: rvp = 70;
                default: rvp = 40;
            endcase
            fill($urandom, int'($urandom_range(0, 4)), rvp, drp, eb, 0);
            release_fill();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
